// File: rtl/alb_pkg.sv
// rtl/alb_pkg.sv - shared opcode, flag index and width constants for the ALB pipe
//
// Purpose:
//    Common definitions imported by alb_core and alb_pipe.
//    - OP_W and the eight opcodes OP_ADD..OP_PASS.
//    - Bit positions of the co/vo/no/zo flags inside the packed flag word
//      that the pipe stages carry alongside f.
//    - pack_flags(): builds that flag word from the individual flags.
package alb_pkg;

   localparam int OP_W = 3;

   localparam logic [OP_W-1:0] OP_ADD  = 3'b000;
   localparam logic [OP_W-1:0] OP_SUB  = 3'b001;
   localparam logic [OP_W-1:0] OP_AND  = 3'b010;
   localparam logic [OP_W-1:0] OP_OR   = 3'b011;
   localparam logic [OP_W-1:0] OP_XOR  = 3'b100;
   localparam logic [OP_W-1:0] OP_SHL  = 3'b101;
   localparam logic [OP_W-1:0] OP_SHR  = 3'b110;
   localparam logic [OP_W-1:0] OP_PASS = 3'b111;

   // Layout of the flag word stored in each pipe stage
   localparam int FLAG_CO = 0;
   localparam int FLAG_VO = 1;
   localparam int FLAG_NO = 2;
   localparam int FLAG_ZO = 3;
   localparam int FLAG_W  = 4;

   function automatic logic [FLAG_W-1:0] pack_flags(input logic co, input logic vo,
                                                   input logic no, input logic zo);
      logic [FLAG_W-1:0] fl;
      fl          = '0;
      fl[FLAG_CO] = co;
      fl[FLAG_VO] = vo;
      fl[FLAG_NO] = no;
      fl[FLAG_ZO] = zo;
      return fl;
   endfunction

endpackage

// File: rtl/alb_core.sv
// rtl/alb_core.sv - combinational arithmetic/logic core of the ALB pipe
//
// Purpose:
//    Computes result f and flags co/vo/no/zo from a/b/ci and opcode i in a
//    single combinational step. The pipe registers only this core's outputs.
//    Optional feature macro: ALB_SAT_EN
//       defined   - ADD/SUB clamp to the signed extreme on overflow
//                   (vo still set, co keeps the raw carry, no/zo follow clamped f)
//       undefined - ADD/SUB wrap modulo 2^DATA_WIDTH
//
// Ports:
//    a, b   in  DATA_WIDTH  operands
//    ci     in  1           carry in, used by ADD/SUB only (SUB: 1 = no borrow)
//    i      in  OP_W        opcode
//    f      out DATA_WIDTH  result
//    co     out 1           carry out (ADD/SUB) or shifted-out bit (SHL/SHR)
//    vo     out 1           signed overflow (ADD/SUB)
//    no     out 1           f[MSB]
//    zo     out 1           f == 0
module alb_core
   import alb_pkg::*;
#(
   parameter int DATA_WIDTH = 11
) (
   input  logic [DATA_WIDTH-1:0] a,
   input  logic [DATA_WIDTH-1:0] b,
   input  logic                  ci,
   input  logic [OP_W-1:0]       i,
   output logic [DATA_WIDTH-1:0] f,
   output logic                  co,
   output logic                  vo,
   output logic                  no,
   output logic                  zo
);

   localparam int MSB = DATA_WIDTH - 1;

   logic [DATA_WIDTH-1:0] b_op;
   logic [DATA_WIDTH:0]   sum;
   logic [DATA_WIDTH-1:0] raw;
   logic                  ovf;

   // SUB reuses the adder with ~b, so one adder covers both arithmetic ops
   always_comb begin
      b_op = (i == OP_SUB) ? ~b : b;
      sum  = {1'b0, a} + {1'b0, b_op} + {{DATA_WIDTH{1'b0}}, ci};
   end

   always_comb begin
      raw = '0;
      co  = 1'b0;
      ovf = 1'b0;
      case (i)
         OP_ADD, OP_SUB: begin
            raw = sum[MSB:0];
            co  = sum[DATA_WIDTH];
            // Overflow: both adder inputs share a sign that the result does not
            ovf = (a[MSB] == b_op[MSB]) && (sum[MSB] != a[MSB]);
         end
         OP_AND: raw = a & b;
         OP_OR:  raw = a | b;
         OP_XOR: raw = a ^ b;
         OP_SHL: begin
            raw = {a[MSB-1:0], 1'b0};
            co  = a[MSB];
         end
         OP_SHR: begin
            raw = {1'b0, a[MSB:1]};
            co  = a[0];
         end
         default: raw = a;
      endcase
   end

   always_comb begin
`ifdef ALB_SAT_EN
      // On overflow the true result has the sign of a, so clamp towards it
      if (ovf) begin
         f = a[MSB] ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : {1'b0, {(DATA_WIDTH-1){1'b1}}};
      end else begin
         f = raw;
      end
`else
      f = raw;
`endif
      vo = ovf;
      no = f[MSB];
      zo = (f == '0);
   end

endmodule

// File: rtl/alb_pipe.sv
// rtl/alb_pipe.sv - elastic pipelined ALB with valid/ready handshakes and sticky status
//
// Purpose:
//    alb_core sits in front of stage 0; PIPE_STAGES registers then carry
//    f plus its flags to the output. Each stage moves forward when the next
//    stage is empty or moving, so bubbles collapse and a full pipe holds
//    PIPE_STAGES results. Latency is PIPE_STAGES cycles, throughput 1/cycle.
//    Optional feature macro: ALB_SAT_EN (saturating ADD/SUB, see alb_core).
//
// Ports:
//    clk         in  1           rising-edge clock
//    reset       in  1           asynchronous active-low reset
//    in_valid    in  1           a/b/ci/i valid
//    in_ready    out 1           input accepted this cycle when in_valid is high
//    a, b        in  DATA_WIDTH  operands
//    ci          in  1           carry in
//    i           in  3           opcode
//    out_valid   out 1           f and flags valid
//    out_ready   in  1           downstream takes the result
//    f           out DATA_WIDTH  result
//    co/vo/no/zo out 1 each      flags of f
//    sticky_co   out 1           OR of delivered co since last clear
//    sticky_vo   out 1           OR of delivered vo since last clear
//    clr_sticky  in  1           synchronous clear of the sticky flags
module alb_pipe
   import alb_pkg::*;
#(
   parameter int DATA_WIDTH  = 11,
   parameter int PIPE_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] a,
   input  logic [DATA_WIDTH-1:0] b,
   input  logic                  ci,
   input  logic [2:0]            i,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] f,
   output logic                  co,
   output logic                  vo,
   output logic                  no,
   output logic                  zo,
   output logic                  sticky_co,
   output logic                  sticky_vo,
   input  logic                  clr_sticky
);

   localparam int LAST = PIPE_STAGES - 1;

   // Core outputs
   logic [DATA_WIDTH-1:0] core_f;
   logic                  core_co;
   logic                  core_vo;
   logic                  core_no;
   logic                  core_zo;

   // Stage storage
   logic [PIPE_STAGES-1:0] st_valid;
   logic [DATA_WIDTH-1:0]  st_f  [PIPE_STAGES];
   logic [FLAG_W-1:0]      st_fl [PIPE_STAGES];

   // Handshake chain
   logic [PIPE_STAGES-1:0] adv;
   logic [PIPE_STAGES-1:0] load;
   logic [DATA_WIDTH-1:0]  src_f  [PIPE_STAGES];
   logic [FLAG_W-1:0]      src_fl [PIPE_STAGES];
   logic                   accept;
   logic                   xfer;

   alb_core #(
      .DATA_WIDTH(DATA_WIDTH)
   ) u_core (
      .a  (a),
      .b  (b),
      .ci (ci),
      .i  (i),
      .f  (core_f),
      .co (core_co),
      .vo (core_vo),
      .no (core_no),
      .zo (core_zo)
   );

   // Walk from the output back to stage 0. "rdy" is whether the stage in
   // front of the one being visited can take a new entry this cycle; it
   // reduces to out_ready OR any empty stage further down.
   always_comb begin
      logic rdy;
      adv = '0;
      rdy = out_ready;
      for (int k = LAST; k >= 0; k--) begin
         adv[k] = st_valid[k] && rdy;
         rdy    = !st_valid[k] || rdy;
      end
      in_ready = rdy;
   end

   assign accept = in_valid && in_ready;

   // Per-stage load strobe and data source (stage 0 is fed by the core)
   always_comb begin
      load[0]   = accept;
      src_f[0]  = core_f;
      src_fl[0] = pack_flags(core_co, core_vo, core_no, core_zo);
      for (int k = 1; k < PIPE_STAGES; k++) begin
         load[k]   = adv[k-1];
         src_f[k]  = st_f[k-1];
         src_fl[k] = st_fl[k-1];
      end
   end

   // Data only changes on load, which keeps f/flags frozen during a stall
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         st_valid <= '0;
         for (int k = 0; k < PIPE_STAGES; k++) begin
            st_f[k]  <= '0;
            st_fl[k] <= '0;
         end
      end else begin
         for (int k = 0; k < PIPE_STAGES; k++) begin
            st_valid[k] <= load[k] || (st_valid[k] && !adv[k]);
            if (load[k]) begin
               st_f[k]  <= src_f[k];
               st_fl[k] <= src_fl[k];
            end
         end
      end
   end

   assign out_valid = st_valid[LAST];
   assign f         = st_f[LAST];
   assign co        = st_fl[LAST][FLAG_CO];
   assign vo        = st_fl[LAST][FLAG_VO];
   assign no        = st_fl[LAST][FLAG_NO];
   assign zo        = st_fl[LAST][FLAG_ZO];

   assign xfer = out_valid && out_ready;

   // A clear drops the accumulated value, but a result delivered in the
   // same cycle still lands in the freshly cleared register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sticky_co <= 1'b0;
         sticky_vo <= 1'b0;
      end else if (clr_sticky) begin
         sticky_co <= xfer && co;
         sticky_vo <= xfer && vo;
      end else if (xfer) begin
         sticky_co <= sticky_co || co;
         sticky_vo <= sticky_vo || vo;
      end
   end

endmodule
